// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: sub-word load/store handling over a req/ack data bus, with stall,
// alignment-fault and ack-timeout reporting, feeding the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EX_MEM_alu_result,
  input  logic [31:0] EX_MEM_B_value,
  input  logic [4:0]  EX_MEM_dst_reg,
  input  logic [5:0]  EX_MEM_opcode,
  input  logic        EX_MEM_mem_read,
  input  logic        EX_MEM_mem_write,
  input  logic        EX_MEM_wb_reg_write,
  input  logic        EX_MEM_wb_mem_to_reg,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output logic [31:0] mem_fwd_val,
  output logic        mem_misaligned,
  output logic        mem_bus_err,
  output logic [31:0] MEM_WB_alu_result,
  output logic [31:0] MEM_WB_mem_data,
  output logic [4:0]  MEM_WB_dst_reg,
  output logic        MEM_WB_wb_reg_write,
  output logic        MEM_WB_wb_mem_to_reg
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [7:0] LAST_CNT = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        misal_q, misal_d, berr_q, berr_d;
  logic [31:0] wb_alu_q, wb_alu_d, wb_data_q, wb_data_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic        wb_rw_q, wb_rw_d, wb_m2r_q, wb_m2r_d;

  logic        mem_op, is_byte, is_half, load_signed, misaligned;
  logic [31:0] store_wdata, load_data;
  logic [3:0]  store_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    mem_op      = EX_MEM_mem_read | EX_MEM_mem_write;
    is_byte     = (EX_MEM_opcode == OP_LB) || (EX_MEM_opcode == OP_LBU) || (EX_MEM_opcode == OP_SB);
    is_half     = (EX_MEM_opcode == OP_LH) || (EX_MEM_opcode == OP_LHU) || (EX_MEM_opcode == OP_SH);
    load_signed = (EX_MEM_opcode == OP_LB) || (EX_MEM_opcode == OP_LH);
    misaligned  = is_half ? EX_MEM_alu_result[0] : (!is_byte && (EX_MEM_alu_result[1:0] != 2'b00));
  end

  // Store lane steering and load extraction; unknown opcodes fall through as word accesses.
  always_comb begin
    store_wdata = EX_MEM_B_value;
    store_be    = 4'b1111;
    if (is_byte) begin
      store_wdata = {4{EX_MEM_B_value[7:0]}};
      store_be    = 4'b0001 << EX_MEM_alu_result[1:0];
    end else if (is_half) begin
      store_wdata = {2{EX_MEM_B_value[15:0]}};
      store_be    = EX_MEM_alu_result[1] ? 4'b1100 : 4'b0011;
    end

    ld_byte   = 8'(dmem.dmem_rdata >> {EX_MEM_alu_result[1:0], 3'b000});
    ld_half   = EX_MEM_alu_result[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    load_data = dmem.dmem_rdata;
    if (is_byte) begin
      load_data = load_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
    end else if (is_half) begin
      load_data = load_signed ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    misal_d   = 1'b0;
    berr_d    = 1'b0;
    mem_stall = 1'b0;
    wb_alu_d  = EX_MEM_alu_result;
    wb_data_d = 32'h0;
    wb_dst_d  = EX_MEM_dst_reg;
    wb_rw_d   = EX_MEM_wb_reg_write;
    wb_m2r_d  = EX_MEM_wb_mem_to_reg;

    case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          state_d   = ACCESS;
          cnt_d     = 8'h0;
          req_d     = 1'b1;
          we_d      = EX_MEM_mem_write;
          addr_d    = {EX_MEM_alu_result[31:2], 2'b00};
          wdata_d   = EX_MEM_mem_write ? store_wdata : 32'h0;
          be_d      = EX_MEM_mem_write ? store_be : 4'b1111;
          mem_stall = 1'b1;
          wb_rw_d   = 1'b0;
          wb_m2r_d  = 1'b0;
        end else if (mem_op) begin
          misal_d  = 1'b1;
          wb_rw_d  = 1'b0;
          wb_m2r_d = 1'b0;
        end
      end
      ACCESS: begin
        // Ack wins over a simultaneous timeout; both release the stall in the same cycle.
        if (dmem.dmem_ack) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          be_d      = 4'b0000;
          wb_data_d = EX_MEM_mem_read ? load_data : 32'h0;
        end else if (cnt_q == LAST_CNT) begin
          state_d  = IDLE;
          req_d    = 1'b0;
          we_d     = 1'b0;
          be_d     = 4'b0000;
          berr_d   = 1'b1;
          wb_rw_d  = 1'b0;
          wb_m2r_d = 1'b0;
        end else begin
          cnt_d     = cnt_q + 8'h1;
          mem_stall = 1'b1;
          wb_rw_d   = 1'b0;
          wb_m2r_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'h0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'b0000;
      misal_q   <= 1'b0;
      berr_q    <= 1'b0;
      wb_alu_q  <= 32'h0;
      wb_data_q <= 32'h0;
      wb_dst_q  <= 5'h0;
      wb_rw_q   <= 1'b0;
      wb_m2r_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      misal_q   <= misal_d;
      berr_q    <= berr_d;
      wb_alu_q  <= wb_alu_d;
      wb_data_q <= wb_data_d;
      wb_dst_q  <= wb_dst_d;
      wb_rw_q   <= wb_rw_d;
      wb_m2r_q  <= wb_m2r_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  assign mem_fwd_val          = EX_MEM_alu_result;
  assign mem_misaligned       = misal_q;
  assign mem_bus_err          = berr_q;
  assign MEM_WB_alu_result    = wb_alu_q;
  assign MEM_WB_mem_data      = wb_data_q;
  assign MEM_WB_dst_reg       = wb_dst_q;
  assign MEM_WB_wb_reg_write  = wb_rw_q;
  assign MEM_WB_wb_mem_to_reg = wb_m2r_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB contents are queued when an instruction
// is driven and compared when the stage retires it; bus-side behaviour is checked inline.
module tb_mem_stage;
  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] exAlu, exB;
  logic [4:0]  exDst;
  logic [5:0]  exOp;
  logic        exRd, exWr, exRw, exM2r;
  logic        memStall, memMis, memBerr;
  logic [31:0] memFwd, wbAlu, wbData;
  logic [4:0]  wbDst;
  logic        wbRw, wbM2r;

  mem_stage_if dmemBus ();

  mem_stage #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .EX_MEM_alu_result    (exAlu),
    .EX_MEM_B_value       (exB),
    .EX_MEM_dst_reg       (exDst),
    .EX_MEM_opcode        (exOp),
    .EX_MEM_mem_read      (exRd),
    .EX_MEM_mem_write     (exWr),
    .EX_MEM_wb_reg_write  (exRw),
    .EX_MEM_wb_mem_to_reg (exM2r),
    .dmem                 (dmemBus.master),
    .mem_stall            (memStall),
    .mem_fwd_val          (memFwd),
    .mem_misaligned       (memMis),
    .mem_bus_err          (memBerr),
    .MEM_WB_alu_result    (wbAlu),
    .MEM_WB_mem_data      (wbData),
    .MEM_WB_dst_reg       (wbDst),
    .MEM_WB_wb_reg_write  (wbRw),
    .MEM_WB_wb_mem_to_reg (wbM2r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  dst;
    logic        rw;
    logic        m2r;
    bit          full;
    bit          checkData;
  } wbExp_t;

  wbExp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] modelLoad(input logic [5:0] op, input logic [1:0] off, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (op)
      6'h20:   return {{24{b[7]}}, b};
      6'h24:   return {24'h0, b};
      6'h21:   return {{16{h[15]}}, h};
      6'h25:   return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic [35:0] modelStore(input logic [5:0] op, input logic [1:0] off, input logic [31:0] b);
    logic [3:0] be;
    case (op)
      6'h28: begin
        case (off)
          2'd0:    be = 4'b0001;
          2'd1:    be = 4'b0010;
          2'd2:    be = 4'b0100;
          default: be = 4'b1000;
        endcase
        return {be, b[7:0], b[7:0], b[7:0], b[7:0]};
      end
      6'h29:   return {(off[1] ? 4'b1100 : 4'b0011), b[15:0], b[15:0]};
      default: return {4'b1111, b};
    endcase
  endfunction

  function automatic bit modelMisaligned(input logic [5:0] op, input logic [1:0] off);
    if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 1'b0;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29) return off[0];
    return off != 2'b00;
  endfunction

  task automatic compareWb(input string tag);
    wbExp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, ".sbEmpty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, ".wbRw"}, 32'(wbRw), 32'(e.rw));
    if (e.full) begin
      checkOutput({tag, ".wbAlu"}, wbAlu, e.alu);
      checkOutput({tag, ".wbDst"}, 32'(wbDst), 32'(e.dst));
      checkOutput({tag, ".wbM2r"}, 32'(wbM2r), 32'(e.m2r));
    end
    if (e.checkData) checkOutput({tag, ".wbData"}, wbData, e.data);
  endtask

  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [31:0] alu,
                               input logic [31:0] b, input logic [4:0] dst, input logic rd, input logic wr,
                               input logic rw, input logic m2r, input int ackDelay, input logic [31:0] rdata);
    wbExp_t      e;
    logic [35:0] st;
    bit          timedOut, done;
    int          stallCycles, reqCycles;
    exAlu = alu; exB = b; exDst = dst; exOp = op;
    exRd = rd; exWr = wr; exRw = rw; exM2r = m2r;
    e.alu = alu; e.dst = dst; e.rw = rw; e.m2r = m2r;
    e.data = 32'h0; e.full = 1'b1; e.checkData = 1'b1;
    if (!rd && !wr) begin
      sb.push_back(e);
      #1;
      checkOutput({tag, ".stall"}, 32'(memStall), 32'd0);
      checkOutput({tag, ".fwd"}, memFwd, alu);
      tick();
      checkOutput({tag, ".misPulse"}, 32'(memMis), 32'd0);
      checkOutput({tag, ".berrPulse"}, 32'(memBerr), 32'd0);
      compareWb(tag);
    end else if (modelMisaligned(op, alu[1:0])) begin
      e.rw = 1'b0; e.full = 1'b0; e.checkData = 1'b0;
      sb.push_back(e);
      #1;
      checkOutput({tag, ".stall"}, 32'(memStall), 32'd0);
      tick();
      checkOutput({tag, ".mis"}, 32'(memMis), 32'd1);
      checkOutput({tag, ".req"}, 32'(dmemBus.dmem_req), 32'd0);
      compareWb(tag);
    end else begin
      timedOut = (ackDelay < 0) || (ackDelay >= ACK_TIMEOUT);
      if (timedOut) begin
        e.rw = 1'b0; e.full = 1'b0; e.checkData = 1'b0;
      end else begin
        e.checkData = rd;
        e.data = modelLoad(op, alu[1:0], rdata);
      end
      sb.push_back(e);
      st = modelStore(op, alu[1:0], b);
      #1;
      checkOutput({tag, ".stallIdle"}, 32'(memStall), 32'd1);
      stallCycles = 1; reqCycles = 0; done = 1'b0;
      tick();
      checkOutput({tag, ".req"}, 32'(dmemBus.dmem_req), 32'd1);
      checkOutput({tag, ".we"}, 32'(dmemBus.dmem_we), 32'(wr));
      checkOutput({tag, ".addr"}, dmemBus.dmem_addr, {alu[31:2], 2'b00});
      checkOutput({tag, ".be"}, 32'(dmemBus.dmem_be), wr ? 32'(st[35:32]) : 32'hF);
      if (wr) checkOutput({tag, ".wdata"}, dmemBus.dmem_wdata, st[31:0]);
      for (int c = 0; c < 64 && !done; c++) begin
        if (dmemBus.dmem_req) reqCycles++;
        if (c == ackDelay) begin
          dmemBus.dmem_ack   = 1'b1;
          dmemBus.dmem_rdata = rdata;
        end
        #1;
        if (memStall) stallCycles++;
        else done = 1'b1;
        tick();
        dmemBus.dmem_ack = 1'b0;
      end
      if (!done) checkOutput({tag, ".ackBound"}, 32'd0, 32'd1);
      checkOutput({tag, ".stallCycles"}, 32'(stallCycles), timedOut ? 32'(ACK_TIMEOUT) : 32'(ackDelay + 1));
      checkOutput({tag, ".reqCycles"}, 32'(reqCycles), timedOut ? 32'(ACK_TIMEOUT) : 32'(ackDelay + 1));
      checkOutput({tag, ".berr"}, 32'(memBerr), 32'(timedOut));
      checkOutput({tag, ".reqDrop"}, 32'(dmemBus.dmem_req), 32'd0);
      compareWb(tag);
    end
  endtask

  task automatic nop(input string tag);
    applyStimulus(tag, 6'h00, 32'h0000_0042, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0);
  endtask

  logic [5:0] opTable [8];

  initial begin
    opTable = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    rst_n = 1'b0;
    exAlu = 32'h0; exB = 32'h0; exDst = 5'h0; exOp = 6'h0;
    exRd = 1'b0; exWr = 1'b0; exRw = 1'b0; exM2r = 1'b0;
    dmemBus.dmem_ack = 1'b0; dmemBus.dmem_rdata = 32'h0;
    tick();
    tick();
    checkOutput("rst.wbRw", 32'(wbRw), 32'd0);
    checkOutput("rst.wbAlu", wbAlu, 32'd0);
    checkOutput("rst.wbData", wbData, 32'd0);
    checkOutput("rst.req", 32'(dmemBus.dmem_req), 32'd0);
    checkOutput("rst.be", 32'(dmemBus.dmem_be), 32'd0);
    checkOutput("rst.mis", 32'(memMis), 32'd0);
    checkOutput("rst.berr", 32'(memBerr), 32'd0);
    rst_n = 1'b1;

    applyStimulus("alu0", 6'h00, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0);
    applyStimulus("alu1", 6'h0F, 32'hCAFE_0001, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0);
    applyStimulus("alu2", 6'h00, 32'h0000_0000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);

    applyStimulus("lb",  6'h20, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'h80FF_FF11);
    applyStimulus("lbu", 6'h24, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'h80FF_FF11);
    applyStimulus("lh",  6'h21, 32'h0000_0102, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h8001_7FFF);
    applyStimulus("lhu", 6'h25, 32'h0000_0100, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h8001_7FFF);
    applyStimulus("lw",  6'h23, 32'h0000_0300, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'hDEAD_BEEF);
    applyStimulus("sh",  6'h29, 32'h0000_0202, 32'hAAAA_BEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    applyStimulus("sb",  6'h28, 32'h0000_0203, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 32'h0);
    applyStimulus("sw",  6'h2B, 32'h0000_0400, 32'h0BAD_CAFE, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 32'h0);
    applyStimulus("lwMis", 6'h23, 32'h0000_0301, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h0);
    nop("afterLwMis");
    applyStimulus("lhMis", 6'h21, 32'h0000_0101, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h0);
    nop("afterLhMis");

    applyStimulus("swTimeout", 6'h2B, 32'h0000_0500, 32'h1111_2222, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 32'h0);
    nop("afterTimeout");
    applyStimulus("swLateAck", 6'h2B, 32'h0000_0500, 32'h1111_2222, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, ACK_TIMEOUT - 1, 32'h0);
    nop("afterLateAck");

    for (int i = 0; i < 10; i++) begin
      logic [5:0]  op;
      logic [31:0] addr;
      logic        isLoad;
      op = opTable[$urandom_range(0, 7)];
      isLoad = (op < 6'h28);
      addr = $urandom & 32'hFFFF_FFFC;
      if (op == 6'h20 || op == 6'h24 || op == 6'h28) addr[1:0] = 2'($urandom_range(0, 3));
      else if (op == 6'h21 || op == 6'h25 || op == 6'h29) addr[1] = 1'($urandom_range(0, 1));
      applyStimulus("rnd", op, addr, $urandom, 5'($urandom_range(1, 31)), isLoad, !isLoad,
                    isLoad, isLoad, $urandom_range(0, 4), $urandom);
    end

    exAlu = 32'h0000_0600; exOp = 6'h23; exRd = 1'b1; exWr = 1'b0; exRw = 1'b1; exM2r = 1'b1; exDst = 5'd4;
    tick();
    tick();
    checkOutput("midRst.reqBefore", 32'(dmemBus.dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRst.req", 32'(dmemBus.dmem_req), 32'd0);
    checkOutput("midRst.wbRw", 32'(wbRw), 32'd0);
    checkOutput("midRst.wbAlu", wbAlu, 32'd0);
    exRd = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus("lwAfterRst", 6'h23, 32'h0000_0600, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h0BAD_F00D);
    nop("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline MEM stage. Consumes the EX/MEM pipeline register fields and performs data-memory loads and stores over a req/ack bus.
- Aligns and sign-extends sub-word loads and merges sub-word stores via byte enables.
- Drives the MEM/WB pipeline register, the MEM-side forwarding value and a pipeline stall while an access is outstanding.

Parameters:
- ACK_TIMEOUT, 16, maximum cycles waiting for dmem_ack before a bus error is declared; range 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- EX_MEM_alu_result  in  32  effective address or ALU result
- EX_MEM_B_value  in  32  store data
- EX_MEM_dst_reg  in  5  destination register
- EX_MEM_opcode  in  6  instruction opcode
- EX_MEM_mem_read  in  1  load
- EX_MEM_mem_write  in  1  store
- EX_MEM_wb_reg_write  in  1  writeback enable
- EX_MEM_wb_mem_to_reg  in  1  writeback selects memory data
- dmem_req  out  1  request valid
- dmem_we  out  1  write
- dmem_addr  out  32  word address, bits[1:0]=0
- dmem_wdata  out  32  lane-aligned write data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; rdata valid in the same cycle for reads
- dmem_rdata  in  32  read word
- mem_stall  out  1  hold IF/ID/EX and the EX/MEM register
- mem_fwd_val  out  32  equals EX_MEM_alu_result (combinational)
- mem_misaligned  out  1  one-cycle pulse, alignment fault
- mem_bus_err  out  1  one-cycle pulse, ack timeout
- MEM_WB_alu_result  out  32  registered
- MEM_WB_mem_data  out  32  registered, extended load data
- MEM_WB_dst_reg  out  5  registered
- MEM_WB_wb_reg_write  out  1  registered
- MEM_WB_wb_mem_to_reg  out  1  registered

Behaviour:
- Reset (rst_n low, asynchronous):
  - All MEM_WB_* outputs, dmem_req, dmem_we, dmem_be, mem_misaligned and mem_bus_err are 0.
  - FSM goes to IDLE; the timeout counter is cleared.
- Opcodes:
  - LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25: loads.
  - SB 0x28, SH 0x29, SW 0x2B: stores.
  - A mem_read/mem_write with any other opcode is treated as a word access.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- FSM states: IDLE, ACCESS.
  - IDLE, no mem op: MEM_WB registers capture the inputs every cycle with MEM_WB_mem_data=0. Single-cycle latency; mem_stall=0.
  - IDLE, aligned mem op:
    - Enter ACCESS. dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are registered and asserted from the next cycle.
    - mem_stall is asserted combinationally in this same cycle and stays high until ack.
    - MEM_WB_wb_reg_write is written 0 (bubble) until completion.
  - IDLE, misaligned op:
    - No request is issued; mem_misaligned pulses.
    - MEM_WB captures a bubble (wb_reg_write=0); no stall.
  - ACCESS, dmem_ack=1:
    - Drop dmem_req; MEM_WB captures the instruction and the load data; go to IDLE.
    - mem_stall deasserts in that cycle, so the next instruction is sampled on the following edge.
  - ACCESS, no ack: counter increments. When it reaches ACK_TIMEOUT:
    - Drop dmem_req and pulse mem_bus_err.
    - Write a bubble to MEM_WB; go to IDLE.
  - Request outputs are held stable throughout ACCESS.
- Store lanes (byte n = bits[8n+7:8n]):
  - SB: wdata replicates B[7:0] in every lane; be = one-hot of addr[1:0] (addr 0 -> 0001, addr 3 -> 1000).
  - SH: wdata = {B[15:0],B[15:0]}; be = 0011 if addr[1]=0, else 1100.
  - SW: wdata = B; be = 1111.
- Load extraction: the selected byte or half of rdata is shifted to bit 0. LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata through. Loads drive be=1111.
- Simultaneous events: an ack in the same cycle the counter reaches ACK_TIMEOUT counts as success; no bus error.
- Reset mid-access: dmem_req drops immediately; the access is abandoned.
- mem_stall is never asserted in IDLE unless a new aligned access is present.

Test Plan:
- Back-to-back ALU ops (reg_write=1, dst 5, result 0x1234) -> MEM_WB updates one cycle later, MEM_WB_mem_data=0, mem_stall never asserted.
- LB addr 0x103, ack after 3 cycles with rdata 0x80FF_FF11 -> dmem_addr 0x100, be 1111, stall held 4 cycles, MEM_WB_mem_data 0xFFFF_FF80; LBU gives 0x0000_0080.
- SH addr 0x202, B=0xAAAA_BEEF, immediate ack -> dmem_addr 0x200, be 1100, wdata 0xBEEF_BEEF, MEM_WB_wb_reg_write=0.
- LW addr 0x301 -> mem_misaligned pulses once, dmem_req stays 0, MEM_WB_wb_reg_write=0, no stall.
- SW with no ack, ACK_TIMEOUT=16 -> req high exactly 16 cycles, mem_bus_err pulses, stall releases, FSM in IDLE; repeat with ack on cycle 16 -> success, no error.
- rst_n low during ACCESS -> dmem_req and MEM_WB_* are 0 asynchronously; after release, a fresh LW completes normally.
